// File: rtl/emg_adc_collector.sv
`default_nettype none
// ============================================================================
// Module   : emg_adc_collector
// Purpose  : Receive side of the EMG acquisition chain. Deserializes the SAR
//            ADC's MSB-first serial result for each conversion, tags it with
//            the channel captured at START, and queues {tag, sample} in a
//            show-ahead FIFO drained by a valid/ready handshake.
// Ports    : CLK_EMG      ADC clock, all registers on rising edge
//            RESET        synchronous active-high reset
//            EN_ADC_EMG   gates START_EMG (running conversion still completes)
//            START_EMG    conversion-start pulse
//            CH_SEL_EMG   channel tag, valid with START_EMG
//            ADC_DOUT     serial SAR result, MSB first
//            CLR_ERR      clears OVERFLOW and START_ERR
//            DATA_OUT     FIFO head {channel[3:0], sample}, 0 when empty
//            DATA_VALID   FIFO not empty
//            DATA_READY   downstream accepts the head entry
//            FRAME_START  head entry carries channel 0
//            FIFO_LEVEL   current occupancy
//            OVERFLOW     sticky: sample dropped on a full FIFO
//            START_ERR    sticky: START arrived during a conversion
// Revision : 1.0 - initial release
// ============================================================================
module emg_adc_collector #(
  parameter int ADC_BITS    = 10,
  parameter int DOUT_OFFSET = 2,
  parameter int NUM_CH      = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        CLK_EMG,
  input  logic                        RESET,
  input  logic                        EN_ADC_EMG,
  input  logic                        START_EMG,
  input  logic [3:0]                  CH_SEL_EMG,
  input  logic                        ADC_DOUT,
  input  logic                        CLR_ERR,
  output logic [ADC_BITS+3:0]         DATA_OUT,
  output logic                        DATA_VALID,
  input  logic                        DATA_READY,
  output logic                        FRAME_START,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERFLOW,
  output logic                        START_ERR
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(ADC_BITS + 1);
  localparam int c_ENT_W = ADC_BITS + 4;

  localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(ADC_BITS - 1);
  // WAIT lasts DOUT_OFFSET-1 cycles; the counter starts at 0 on entry.
  localparam logic [2:0]         c_WAIT_LAST = 3'((DOUT_OFFSET > 1) ? DOUT_OFFSET - 2 : 0);
  localparam logic [c_PTR_W:0]   c_FULL_LVL  = (c_PTR_W + 1)'(FIFO_DEPTH);

  // Elaboration-time guard against unsupported parameter sets.
  if (DOUT_OFFSET < 1 || DOUT_OFFSET > 4 || NUM_CH < 1 || NUM_CH > 16 ||
      ADC_BITS < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("emg_adc_collector: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_tag;
  logic [ADC_BITS-1:0]  r_shift;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [2:0]           r_wait_cnt;

  logic                 w_accept;
  logic                 w_abort;
  logic                 w_push;

  logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_level;
  logic                 r_ovf;
  logic                 r_serr;

  logic                 w_valid;
  logic                 w_full;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_drop;
  logic [c_ENT_W-1:0]   w_head;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept    = START_EMG && EN_ADC_EMG;
    // A START is legal in IDLE and PUSH; anywhere else it kills the sample.
    w_abort     = w_accept && ((r_state == S_WAIT) || (r_state == S_SHIFT));
    w_push      = (r_state == S_PUSH);
    w_state_nxt = r_state;

    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_WAIT:  if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_bit_cnt == c_LAST_BIT) w_state_nxt = S_PUSH;
      S_PUSH:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Accepting a START overrides every other transition, including abort.
    if (w_accept) begin
      w_state_nxt = (DOUT_OFFSET == 1) ? S_SHIFT : S_WAIT;
    end
  end

  always_ff @(posedge CLK_EMG) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_tag      <= 4'd0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tag      <= CH_SEL_EMG;
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_wait_cnt <= 3'd0;
      end else begin
        if (r_state == S_WAIT) begin
          r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        if (r_state == S_SHIFT) begin
          r_shift   <= {r_shift[ADC_BITS-2:0], ADC_DOUT};
          r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid = (r_level != '0);
    w_full  = (r_level == c_FULL_LVL);
    w_rd    = w_valid && DATA_READY;
    // A full FIFO still takes the sample if the head leaves on the same edge.
    w_wr    = w_push && (!w_full || w_rd);
    w_drop  = w_push && !w_wr;
    w_head  = r_mem[r_rd_ptr];
  end

  always_ff @(posedge CLK_EMG) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {r_tag, r_shift};
    end
  end

  always_ff @(posedge CLK_EMG) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_serr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (c_PTR_W + 1)'(1);
        2'b01:   r_level <= r_level - (c_PTR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
      // A new error on the clearing edge keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (CLR_ERR) begin
        r_ovf <= 1'b0;
      end
      if (w_abort) begin
        r_serr <= 1'b1;
      end else if (CLR_ERR) begin
        r_serr <= 1'b0;
      end
    end
  end

  // Outputs come from registered state only; memory contents are masked when
  // empty so stale entries never leak onto DATA_OUT.
  always_comb begin
    DATA_VALID  = w_valid;
    DATA_OUT    = w_valid ? w_head : '0;
    FRAME_START = w_valid && (w_head[c_ENT_W-1:ADC_BITS] == 4'd0);
    FIFO_LEVEL  = r_level;
    OVERFLOW    = r_ovf;
    START_ERR   = r_serr;
  end

endmodule
`default_nettype wire

// File: tb/tb_emg_adc_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_emg_adc_collector
// Purpose  : Self-checking bench for emg_adc_collector. A transaction-level
//            model (pending conversion + queue of expected entries) predicts
//            every output after each edge; table vectors and hand sequences
//            add fixed expectations for the documented corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emg_adc_collector;

  localparam int ADC_BITS    = 10;
  localparam int DOUT_OFFSET = 2;
  localparam int NUM_CH      = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int CONV        = DOUT_OFFSET + ADC_BITS; // START edge to write edge

  logic        CLK_EMG = 1'b0;
  logic        RESET = 1'b1;
  logic        EN_ADC_EMG = 1'b0;
  logic        START_EMG = 1'b0;
  logic [3:0]  CH_SEL_EMG = 4'd0;
  logic        ADC_DOUT = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        DATA_READY = 1'b0;
  logic [13:0] DATA_OUT;
  logic        DATA_VALID;
  logic        FRAME_START;
  logic [4:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  logic        START_ERR;

  emg_adc_collector #(
    .ADC_BITS    (ADC_BITS),
    .DOUT_OFFSET (DOUT_OFFSET),
    .NUM_CH      (NUM_CH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLK_EMG     (CLK_EMG),
    .RESET       (RESET),
    .EN_ADC_EMG  (EN_ADC_EMG),
    .START_EMG   (START_EMG),
    .CH_SEL_EMG  (CH_SEL_EMG),
    .ADC_DOUT    (ADC_DOUT),
    .CLR_ERR     (CLR_ERR),
    .DATA_OUT    (DATA_OUT),
    .DATA_VALID  (DATA_VALID),
    .DATA_READY  (DATA_READY),
    .FRAME_START (FRAME_START),
    .FIFO_LEVEL  (FIFO_LEVEL),
    .OVERFLOW    (OVERFLOW),
    .START_ERR   (START_ERR)
  );

  always #5 CLK_EMG = ~CLK_EMG;

  int n_cmp = 0;
  int n_bad = 0;

  // Level-type stimulus held across ticks
  logic s_rst   = 1'b1;
  logic s_en    = 1'b1;
  logic s_ready = 1'b0;
  logic s_clr   = 1'b0;

  // Reference model: one pending conversion plus the queue of entries
  int          edge_n = 0;
  logic [13:0] q[$];
  bit          m_pend = 1'b0;
  int          m_start = 0;
  logic [3:0]  m_ch = 4'd0;
  logic [9:0]  m_val = 10'd0;
  bit          m_ovf = 1'b0;
  bit          m_serr = 1'b0;

  typedef struct {
    logic [3:0]  ch;
    logic [9:0]  sample;
    logic [13:0] exp_out;
    logic        exp_fs;
  } vec_t;

  vec_t        vecs[5];
  logic [9:0]  scan_val[16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Effect of the upcoming edge on the model, from the behavioural rules.
  task automatic model_edge(input logic start, input logic [3:0] ch, input logic [9:0] val);
    bit rd;
    bit push_now;
    bit ovf_set;
    bit serr_set;
    if (s_rst) begin
      q.delete();
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_serr = 1'b0;
    end else begin
      rd       = (q.size() > 0) && s_ready;
      push_now = m_pend && (edge_n == m_start + CONV);
      ovf_set  = 1'b0;
      serr_set = 1'b0;
      if (rd) void'(q.pop_front());
      if (push_now) begin
        if (q.size() < FIFO_DEPTH) q.push_back({m_ch, m_val});
        else ovf_set = 1'b1;
      end
      if (start && s_en) begin
        serr_set = m_pend && !push_now;
        m_pend   = 1'b1;
        m_start  = edge_n;
        m_ch     = ch;
        m_val    = val;
      end else if (push_now) begin
        m_pend = 1'b0;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (s_clr) m_ovf = 1'b0;
      if (serr_set) m_serr = 1'b1;
      else if (s_clr) m_serr = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic start, input logic [3:0] ch, input logic [9:0] val);
    logic [13:0] exp_out;
    int          k;
    RESET      = s_rst;
    EN_ADC_EMG = s_en;
    START_EMG  = start;
    CH_SEL_EMG = ch;
    DATA_READY = s_ready;
    CLR_ERR    = s_clr;
    k = edge_n - m_start - DOUT_OFFSET;
    if (m_pend && k >= 0 && k < ADC_BITS) ADC_DOUT = m_val[ADC_BITS-1-k];
    else ADC_DOUT = 1'($urandom);
    model_edge(start, ch, val);
    @(posedge CLK_EMG);
    #1;
    edge_n++;
    exp_out = (q.size() > 0) ? q[0] : 14'd0;
    check("m_valid", DATA_VALID, (q.size() > 0) ? 1 : 0);
    check("m_data", DATA_OUT, exp_out);
    check("m_frame", FRAME_START, ((q.size() > 0) && (exp_out[13:10] == 4'd0)) ? 1 : 0);
    check("m_level", FIFO_LEVEL, q.size());
    check("m_ovf", OVERFLOW, m_ovf);
    check("m_serr", START_ERR, m_serr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'($urandom), 10'($urandom));
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    idle(2);
    s_rst = 1'b0;
  endtask

  task automatic scan();
    for (int c = 0; c < 16; c++) begin
      scan_val[c] = 10'($urandom);
      tick(1'b1, 4'(c), scan_val[c]);
      idle(CONV + 1);
    end
  endtask

  initial begin
    logic [9:0] v;
    int         since;
    int         gap;
    int         rdy_pct;

    vecs[0] = '{ch: 4'd5,  sample: 10'h2A5, exp_out: 14'h16A5, exp_fs: 1'b0};
    vecs[1] = '{ch: 4'd0,  sample: 10'h3FF, exp_out: 14'h03FF, exp_fs: 1'b1};
    vecs[2] = '{ch: 4'd15, sample: 10'h000, exp_out: 14'h3C00, exp_fs: 1'b0};
    vecs[3] = '{ch: 4'd9,  sample: 10'h155, exp_out: 14'h2555, exp_fs: 1'b0};
    vecs[4] = '{ch: 4'd0,  sample: 10'h001, exp_out: 14'h0001, exp_fs: 1'b1};

    // Reset state
    do_reset();
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_frame", FRAME_START, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_serr", START_ERR, 0);

    // Single conversion timing: channel 5, 0x2A5, write at E12
    tick(1'b1, 4'd5, 10'h2A5);
    idle(CONV - 1);
    check("single_valid_e11", DATA_VALID, 0);
    idle(1);
    check("single_valid_e12", DATA_VALID, 1);
    check("single_data", DATA_OUT, 14'h16A5);
    check("single_level", FIFO_LEVEL, 1);
    s_ready = 1'b1;
    idle(1);
    s_ready = 1'b0;
    check("single_drained", DATA_VALID, 0);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, vecs[i].ch, vecs[i].sample);
      idle(CONV);
      check("vec_data", DATA_OUT, vecs[i].exp_out);
      check("vec_frame", FRAME_START, vecs[i].exp_fs);
      check("vec_level", FIFO_LEVEL, 1);
      s_ready = 1'b1;
      idle(1);
      s_ready = 1'b0;
      check("vec_empty", DATA_VALID, 0);
    end

    // Full scan, then a 17th conversion overflows
    scan();
    check("scan_level", FIFO_LEVEL, 16);
    check("scan_frame", FRAME_START, 1);
    check("scan_head", DATA_OUT, {4'h0, scan_val[0]});
    tick(1'b1, 4'd7, 10'($urandom));
    idle(CONV + 1);
    check("ovf_flag", OVERFLOW, 1);
    check("ovf_level", FIFO_LEVEL, 16);
    check("ovf_head", DATA_OUT, {4'h0, scan_val[0]});
    s_clr = 1'b1;
    idle(1);
    s_clr = 1'b0;
    check("ovf_clr", OVERFLOW, 0);

    // Drain in order, FRAME_START only on the first entry
    s_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_tag", DATA_OUT[13:10], i);
      check("drain_sample", DATA_OUT[9:0], scan_val[i]);
      check("drain_frame", FRAME_START, (i == 0) ? 1 : 0);
      idle(1);
    end
    s_ready = 1'b0;
    check("drain_level", FIFO_LEVEL, 0);

    // Full FIFO with a read on the PUSH edge: write accepted
    scan();
    tick(1'b1, 4'd8, 10'h0F0);
    idle(CONV - 1);
    s_ready = 1'b1;
    idle(1);
    s_ready = 1'b0;
    check("fullrd_level", FIFO_LEVEL, 16);
    check("fullrd_ovf", OVERFLOW, 0);
    check("fullrd_head", DATA_OUT, {4'h1, scan_val[1]});

    // Aborted conversion: START ch3 at E0, START ch4 at E6, write at E18
    do_reset();
    tick(1'b1, 4'd3, 10'h111);
    idle(5);
    v = 10'($urandom);
    tick(1'b1, 4'd4, v);
    check("abort_serr", START_ERR, 1);
    idle(11);
    check("abort_level_e17", FIFO_LEVEL, 0);
    idle(1);
    check("abort_level_e18", FIFO_LEVEL, 1);
    check("abort_data", DATA_OUT, {4'h4, v});
    s_clr = 1'b1;
    idle(1);
    s_clr = 1'b0;
    check("abort_clr", START_ERR, 0);

    // Enable low: STARTs ignored
    s_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'd2, 10'($urandom));
      idle(CONV + 1);
    end
    s_en = 1'b1;
    check("en_level", FIFO_LEVEL, 1);
    check("en_serr", START_ERR, 0);

    // Reset at E7 with 3 entries queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'(i + 1), 10'($urandom));
      idle(CONV + 1);
    end
    check("rstmid_pre", FIFO_LEVEL, 3);
    tick(1'b1, 4'd6, 10'h2AA);
    idle(6);
    s_rst = 1'b1;
    idle(1);
    s_rst = 1'b0;
    check("rstmid_level", FIFO_LEVEL, 0);
    check("rstmid_valid", DATA_VALID, 0);
    idle(5);
    check("rstmid_nowr_level", FIFO_LEVEL, 0);
    check("rstmid_nowr_data", DATA_OUT, 0);

    // Randomized traffic against the model
    since = 0;
    gap   = 14;
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0:       rdy_pct = 0;
        1:       rdy_pct = 20;
        2:       rdy_pct = 60;
        default: rdy_pct = 100;
      endcase
      for (int i = 0; i < 250; i++) begin
        s_ready = ($urandom_range(99) < rdy_pct);
        s_en    = ($urandom_range(99) < 92);
        s_clr   = ($urandom_range(99) < 4);
        s_rst   = ($urandom_range(999) < 3);
        since++;
        if (since >= gap) begin
          since = 0;
          gap   = $urandom_range(16, 9);
          tick(1'b1, 4'($urandom), 10'($urandom));
        end else begin
          tick(1'b0, 4'($urandom), 10'($urandom));
        end
      end
    end
    s_rst = 1'b0;
    s_clr = 1'b0;
    s_en  = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
